cp0_nested: RTL and testbench
=============================

Name: cp0_nested

Overview:
Parametrised coprocessor-0 for the pipelined MIPS core, successor to the single-level CP0. Adds:
- a STATUS/EPC save stack for nested exceptions;
- maskable hardware interrupt lines;
- a COUNT/COMPARE timer interrupt.

Sits beside the ID/EX stages: serves mfc0/mtc0, takes exception and eret requests, and drives the redirect address to the PC mux.

Parameters:
NEST_DEPTH, 4, number of saved {STATUS, EPC} pairs (1..8)
IRQ_N, 5, hardware interrupt lines (1..5), mapped to CAUSE.IP[IRQ_N+9:10]
EXC_VECTOR, 32'h00400004, exception/interrupt handler entry address

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
mfc0  in  1  read request
mtc0  in  1  write request
pc  in  32  PC of the faulting/interrupted instruction
addr  in  5  CP0 register index
wdata  in  32  mtc0 write data
exception  in  1  synchronous exception request
eret  in  1  return from exception
cause  in  5  ExcCode for exception
irq  in  IRQ_N  level-sensitive hardware interrupt lines
rdata  out  32  mfc0 read data
status  out  32  current STATUS
exc_addr  out  32  redirect target
irq_take  out  1  interrupt accepted this cycle; pipeline must flush and redirect
nest_level  out  4  stack occupancy, 0..NEST_DEPTH
overflow  out  1  sticky: entry attempted with stack full

Behaviour:
- Implemented registers: COUNT(9), COMPARE(11), STATUS(12), CAUSE(13), EPC(14). Other indices read 0; writes to them are ignored.
- Reset (rst=1 at edge) values:
  - STATUS=32'h0000000F, with bit0=IE and IM=bits[15:8].
  - CAUSE, EPC, COUNT and COMPARE = 0.
  - nest_level=0, overflow=0, stack contents cleared.
  - Reset mid-handler discards the whole stack.
- COUNT increments by 1 every cycle and wraps at 2^32. mtc0 to COUNT loads wdata; the increment is suppressed in that cycle.
- Timer:
  - When COUNT==COMPARE and COMPARE!=0, CAUSE.IP7 (bit15) sets and is sticky.
  - mtc0 to COMPARE loads the value and clears IP7.
- CAUSE.IP[IRQ_N+9:10] is registered from irq every cycle; it is a one-cycle sampled level, not sticky.
- CAUSE.IP[9:8] are software bits, written by mtc0 to CAUSE. All other CAUSE bits are read-only to mtc0.
- pending = CAUSE.IP[15:8] & STATUS[15:8].
- irq_take = STATUS[0] & |pending & ~exception & ~eret. It is combinational.
- Entry, triggered by exception, or by irq_take (using ExcCode 0):
  - if nest_level<NEST_DEPTH: push {STATUS, EPC} and increment nest_level;
  - otherwise: no push, overflow<=1, nest_level unchanged;
  - EPC<=pc; CAUSE[6:2]<=ExcCode; STATUS<=STATUS<<5 (legacy masking semantics).
- eret:
  - if nest_level>0: pop, restoring STATUS and EPC, and decrement nest_level;
  - if nest_level==0: STATUS[0]<=1; EPC unchanged.
- Priority per edge: rst > exception > irq_take > eret > mtc0.
  - A lower-priority request in the same cycle is dropped; mtc0 is not retried.
  - The COUNT increment and the IP sampling always proceed.
- exc_addr = eret ? EPC (pre-pop value) : EXC_VECTOR. It is combinational.
- rdata = mfc0 ? reg[addr] : 0. Combinational, showing pre-edge values; a same-cycle mtc0 is not bypassed.
- status mirrors STATUS. It is the sole source for external interrupt masking.
- Latency: entry and eret take effect at the next edge. Redirect is valid in the request cycle.

Test Plan:
- Reset then mfc0 addr=12 -> rdata=32'h0000000F; nest_level=0; overflow=0; addr=13 -> 0.
- exception, cause=5'd8, pc=32'h00400100 -> exc_addr=32'h00400004. Next cycle: EPC=32'h00400100, CAUSE=32'h00000020, STATUS=32'h000001E0, nest_level=1.
- Three nested exceptions (pcs A, B, C), then three erets:
  - exc_addr successively C, B, A;
  - STATUS restored stepwise to 32'h0000000F;
  - nest_level 3->0.
- NEST_DEPTH=2, three exceptions:
  - overflow=1 and nest_level=2 after the third;
  - the third EPC overwrites the live EPC only;
  - after 2 erets, STATUS=32'h0000000F.
- Timer interrupt:
  - mtc0 COMPARE=32'd20, STATUS=32'h00008001 -> irq_take=1 one cycle after COUNT reaches 20, with exc_addr=EXC_VECTOR and CAUSE[6:2]=0;
  - mtc0 COMPARE clears IP7.
- irq[0]=1 with IM bit10=1, same cycle as exception -> exception wins, irq_take=0, CAUSE[6:2]=cause. With IE=0 after entry, irq is ignored until eret.

Source files
------------

// File: rtl/cp0_nested_if.sv
// Core-side request/response bundle for the nested CP0.
// The core drives requests; CP0 returns read data, redirect and state.
interface cp0_nested_if #(
    parameter int IRQ_N = 5
);
    logic             mfc0;
    logic             mtc0;
    logic [31:0]      pc;
    logic [4:0]       addr;
    logic [31:0]      wdata;
    logic             exception;
    logic             eret;
    logic [4:0]       cause;
    logic [IRQ_N-1:0] irq;
    logic [31:0]      rdata;
    logic [31:0]      status;
    logic [31:0]      exc_addr;
    logic             irq_take;
    logic [3:0]       nest_level;
    logic             overflow;

    modport master (
        output mfc0, mtc0, pc, addr, wdata,
        output exception, eret, cause, irq,
        input  rdata, status, exc_addr,
        input  irq_take, nest_level, overflow
    );

    modport slave (
        input  mfc0, mtc0, pc, addr, wdata,
        input  exception, eret, cause, irq,
        output rdata, status, exc_addr,
        output irq_take, nest_level, overflow
    );
endinterface

// File: rtl/cp0_nested.sv
// Coprocessor 0 with a STATUS/EPC save stack for nested exceptions,
// maskable hardware interrupts and a COUNT/COMPARE timer.
module cp0_nested #(
    parameter int          NEST_DEPTH = 4,
    parameter int          IRQ_N      = 5,
    parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
    input logic         clk,
    input logic         rst,
    cp0_nested_if.slave bus
);
    localparam int AW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam int SD = 1 << AW;
    localparam logic [3:0] DEPTH = 4'(NEST_DEPTH);

    logic [31:0]      count;
    logic [31:0]      compare;
    logic [31:0]      status_r;
    logic [31:0]      epc;
    logic             ip7;
    logic [IRQ_N-1:0] ip_hw;
    logic [1:0]       ip_sw;
    logic [4:0]       exc_code;
    logic [3:0]       lvl;
    logic             ovf;
    logic [31:0]      stk_status [SD];
    logic [31:0]      stk_epc    [SD];

    logic [31:0]   cause_v;
    logic [7:0]    pending;
    logic          take;
    logic          entry;
    logic [4:0]    entry_code;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] pop_idx;

    always_comb begin
        cause_v      = '0;
        cause_v[15]  = ip7;
        cause_v[9:8] = ip_sw;
        cause_v[6:2] = exc_code;
        for (int i = 0; i < IRQ_N; i++) begin
            cause_v[10+i] = ip_hw[i];
        end
    end

    assign pending    = cause_v[15:8] & status_r[15:8];
    assign take       = status_r[0] & (|pending)
                      & ~bus.exception & ~bus.eret;
    assign entry      = bus.exception | take;
    assign entry_code = bus.exception ? bus.cause : 5'd0;
    // At full depth the low bits wrap, but no push happens then.
    assign push_idx   = lvl[AW-1:0];
    assign pop_idx    = push_idx - AW'(1);

    always_comb begin
        bus.rdata = '0;
        if (bus.mfc0) begin
            case (bus.addr)
                5'd9:    bus.rdata = count;
                5'd11:   bus.rdata = compare;
                5'd12:   bus.rdata = status_r;
                5'd13:   bus.rdata = cause_v;
                5'd14:   bus.rdata = epc;
                default: bus.rdata = '0;
            endcase
        end
    end

    assign bus.status     = status_r;
    assign bus.exc_addr   = bus.eret ? epc : EXC_VECTOR;
    assign bus.irq_take   = take;
    assign bus.nest_level = lvl;
    assign bus.overflow   = ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            compare  <= '0;
            status_r <= 32'h0000000F;
            epc      <= '0;
            ip7      <= 1'b0;
            ip_hw    <= '0;
            ip_sw    <= '0;
            exc_code <= '0;
            lvl      <= '0;
            ovf      <= 1'b0;
            for (int i = 0; i < SD; i++) begin
                stk_status[i] <= '0;
                stk_epc[i]    <= '0;
            end
        end else begin
            count <= count + 32'd1;
            ip_hw <= bus.irq;
            if (count == compare && compare != 32'd0) begin
                ip7 <= 1'b1;
            end
            if (entry) begin
                if (lvl < DEPTH) begin
                    stk_status[push_idx] <= status_r;
                    stk_epc[push_idx]    <= epc;
                    lvl                  <= lvl + 4'd1;
                end else begin
                    ovf <= 1'b1;
                end
                epc      <= bus.pc;
                exc_code <= entry_code;
                status_r <= status_r << 5;
            end else if (bus.eret) begin
                if (lvl != 4'd0) begin
                    status_r <= stk_status[pop_idx];
                    epc      <= stk_epc[pop_idx];
                    lvl      <= lvl - 4'd1;
                end else begin
                    status_r[0] <= 1'b1;
                end
            end else if (bus.mtc0) begin
                case (bus.addr)
                    5'd9:  count <= bus.wdata;
                    5'd11: begin
                        compare <= bus.wdata;
                        ip7     <= 1'b0;
                    end
                    5'd12: status_r <= bus.wdata;
                    5'd13: ip_sw <= bus.wdata[9:8];
                    5'd14: epc <= bus.wdata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cp0_nested.sv
// Bench for cp0_nested: directed scenarios plus random traffic on a
// depth-4 and a depth-2 instance against a reference model.
module tb_cp0_nested;
    localparam logic [31:0] VEC = 32'h00400004;

    logic clk = 1'b0;
    logic t_rst, t_mfc0, t_mtc0, t_exc, t_eret;
    logic [31:0] t_pc, t_wdata;
    logic [4:0]  t_addr, t_cause, t_irq;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cp0_nested_if #(.IRQ_N(5)) ia ();
    cp0_nested_if #(.IRQ_N(5)) ib ();

    assign ia.mfc0 = t_mfc0;       assign ib.mfc0 = t_mfc0;
    assign ia.mtc0 = t_mtc0;       assign ib.mtc0 = t_mtc0;
    assign ia.pc = t_pc;           assign ib.pc = t_pc;
    assign ia.addr = t_addr;       assign ib.addr = t_addr;
    assign ia.wdata = t_wdata;     assign ib.wdata = t_wdata;
    assign ia.exception = t_exc;   assign ib.exception = t_exc;
    assign ia.eret = t_eret;       assign ib.eret = t_eret;
    assign ia.cause = t_cause;     assign ib.cause = t_cause;
    assign ia.irq = t_irq;         assign ib.irq = t_irq;

    cp0_nested #(.NEST_DEPTH(4), .IRQ_N(5), .EXC_VECTOR(VEC)) dut_a (
        .clk(clk), .rst(t_rst), .bus(ia.slave)
    );
    cp0_nested #(.NEST_DEPTH(2), .IRQ_N(5), .EXC_VECTOR(VEC)) dut_b (
        .clk(clk), .rst(t_rst), .bus(ib.slave)
    );

    // reference state, index 0 = depth 4, index 1 = depth 2
    logic [31:0] m_cnt[2], m_cmp[2], m_st[2], m_cause[2], m_epc[2];
    logic [31:0] s_st[2][8], s_epc[2][8];
    int          m_lvl[2];
    logic        m_ovf[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int depth(int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic logic m_take(int k);
        logic [7:0] p;
        p = m_cause[k][15:8] & m_st[k][15:8];
        return m_st[k][0] && (p != 8'd0) && !t_exc && !t_eret;
    endfunction

    function automatic logic [31:0] m_reg(int k, logic [4:0] a);
        case (a)
            5'd9:    return m_cnt[k];
            5'd11:   return m_cmp[k];
            5'd12:   return m_st[k];
            5'd13:   return m_cause[k];
            5'd14:   return m_epc[k];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] nc, ncmp, nst, ncause, nepc;
            logic tk;
            if (t_rst) begin
                m_cnt[k] = 0; m_cmp[k] = 0; m_st[k] = 32'hF;
                m_cause[k] = 0; m_epc[k] = 0; m_lvl[k] = 0; m_ovf[k] = 0;
                continue;
            end
            tk = m_take(k);
            nc = m_cnt[k] + 1;
            ncmp = m_cmp[k];
            nst = m_st[k];
            nepc = m_epc[k];
            ncause = m_cause[k];
            ncause[14:10] = t_irq;
            if (m_cnt[k] == m_cmp[k] && m_cmp[k] != 0) ncause[15] = 1'b1;
            if (t_exc || tk) begin
                if (m_lvl[k] < depth(k)) begin
                    s_st[k][m_lvl[k]] = m_st[k];
                    s_epc[k][m_lvl[k]] = m_epc[k];
                    m_lvl[k]++;
                end else begin
                    m_ovf[k] = 1'b1;
                end
                nepc = t_pc;
                ncause[6:2] = t_exc ? t_cause : 5'd0;
                nst = m_st[k] << 5;
            end else if (t_eret) begin
                if (m_lvl[k] > 0) begin
                    m_lvl[k]--;
                    nst = s_st[k][m_lvl[k]];
                    nepc = s_epc[k][m_lvl[k]];
                end else begin
                    nst[0] = 1'b1;
                end
            end else if (t_mtc0) begin
                case (t_addr)
                    5'd9:  nc = t_wdata;
                    5'd11: begin ncmp = t_wdata; ncause[15] = 1'b0; end
                    5'd12: nst = t_wdata;
                    5'd13: ncause[9:8] = t_wdata[9:8];
                    5'd14: nepc = t_wdata;
                    default: ;
                endcase
            end
            m_cnt[k] = nc; m_cmp[k] = ncmp; m_st[k] = nst;
            m_cause[k] = ncause; m_epc[k] = nepc;
        end
    endtask

    task automatic compare_all();
        chk("a_rdata", ia.rdata, t_mfc0 ? m_reg(0, t_addr) : 32'd0);
        chk("a_status", ia.status, m_st[0]);
        chk("a_exc_addr", ia.exc_addr, t_eret ? m_epc[0] : VEC);
        chk("a_irq_take", 32'(ia.irq_take), 32'(m_take(0)));
        chk("a_nest", 32'(ia.nest_level), 32'(m_lvl[0]));
        chk("a_ovf", 32'(ia.overflow), 32'(m_ovf[0]));
        chk("b_rdata", ib.rdata, t_mfc0 ? m_reg(1, t_addr) : 32'd0);
        chk("b_status", ib.status, m_st[1]);
        chk("b_exc_addr", ib.exc_addr, t_eret ? m_epc[1] : VEC);
        chk("b_irq_take", 32'(ib.irq_take), 32'(m_take(1)));
        chk("b_nest", 32'(ib.nest_level), 32'(m_lvl[1]));
        chk("b_ovf", 32'(ib.overflow), 32'(m_ovf[1]));
    endtask

    task automatic idle();
        t_rst = 0; t_mfc0 = 0; t_mtc0 = 0; t_exc = 0; t_eret = 0;
        t_pc = 0; t_wdata = 0; t_addr = 0; t_cause = 0; t_irq = 0;
    endtask

    // called just after a negedge with inputs already set
    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        t_rst = 1;
        tick();
        tick();
        t_rst = 0;
    endtask

    task automatic exc(input logic [31:0] pc, input logic [4:0] c);
        idle();
        t_exc = 1; t_pc = pc; t_cause = c;
        tick();
        idle();
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] seq[3];
        int n;
        idle();
        t_rst = 1;
        @(posedge clk);
        model_update();
        @(negedge clk);
        do_reset();

        // reset state
        t_mfc0 = 1; t_addr = 5'd12; #1;
        chk("rst_status", ia.rdata, 32'h0000000F);
        chk("rst_nest", 32'(ia.nest_level), 0);
        chk("rst_ovf", 32'(ia.overflow), 0);
        t_addr = 5'd13; #1;
        chk("rst_cause", ia.rdata, 32'h0);
        tick();

        // single exception
        idle(); t_exc = 1; t_cause = 5'd8; t_pc = 32'h00400100; #1;
        chk("exc_redirect", ia.exc_addr, 32'h00400004);
        tick();
        idle(); t_mfc0 = 1; t_addr = 5'd14; #1;
        chk("exc_epc", ia.rdata, 32'h00400100);
        t_addr = 5'd13; #1;
        chk("exc_cause", ia.rdata, 32'h00000020);
        chk("exc_status", ia.status, 32'h000001E0);
        chk("exc_nest", 32'(ia.nest_level), 1);
        tick();

        // three nested exceptions, three erets
        do_reset();
        seq[0] = 32'h00001000; seq[1] = 32'h00002000; seq[2] = 32'h00003000;
        for (int i = 0; i < 3; i++) exc(seq[i], 5'(i + 4));
        chk("nest3_a", 32'(ia.nest_level), 3);
        chk("nest3_b", 32'(ib.nest_level), 2);
        chk("ovf_b", 32'(ib.overflow), 1);
        chk("ovf_a", 32'(ia.overflow), 0);
        t_mfc0 = 1; t_addr = 5'd14; #1;
        chk("ovf_b_epc", ib.rdata, 32'h00003000);
        idle();
        for (int i = 2; i >= 0; i--) begin
            t_eret = 1; #1;
            chk("eret_target", ia.exc_addr, seq[i]);
            tick();
            chk("eret_nest", 32'(ia.nest_level), 32'(i));
            if (i == 1) chk("b_after2", ib.status, 32'h0000000F);
        end
        idle();
        chk("eret_status", ia.status, 32'h0000000F);

        // timer interrupt
        do_reset();
        t_mtc0 = 1; t_addr = 5'd11; t_wdata = 32'd20; tick();
        t_addr = 5'd12; t_wdata = 32'h00008001; tick();
        idle();
        n = 0;
        while (!ia.irq_take && n < 60) begin tick(); n++; end
        chk("timer_fired", 32'(n < 60), 1);
        t_mfc0 = 1; t_addr = 5'd9; #1;
        chk("timer_count", ia.rdata, 32'd21);
        chk("timer_vec", ia.exc_addr, VEC);
        tick();
        t_addr = 5'd13; #1;
        chk("timer_code", ia.rdata & 32'h7C, 32'h0);
        chk("timer_ip7", ia.rdata & 32'h8000, 32'h8000);
        idle(); t_mtc0 = 1; t_addr = 5'd11; t_wdata = 32'd0; tick();
        idle(); t_mfc0 = 1; t_addr = 5'd13; #1;
        chk("timer_clr", ia.rdata & 32'h8000, 32'h0);
        tick();

        // irq vs exception
        do_reset();
        t_mtc0 = 1; t_addr = 5'd12; t_wdata = 32'h00000401; t_irq = 5'd1;
        tick();
        t_mtc0 = 0; t_exc = 1; t_cause = 5'd3; t_pc = 32'h00400200; #1;
        chk("irq_vs_exc", 32'(ia.irq_take), 0);
        tick();
        t_exc = 0; t_mfc0 = 1; t_addr = 5'd13;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("irq_masked", 32'(ia.irq_take), 0);
            chk("irq_code", (ia.rdata >> 2) & 32'h1F, 32'd3);
            tick();
        end
        t_mfc0 = 0; t_eret = 1; #1;
        chk("irq_eret", 32'(ia.irq_take), 0);
        tick();
        t_eret = 0; #1;
        chk("irq_after_eret", 32'(ia.irq_take), 1);
        tick();

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = $urandom;
            t_rst = (r[7:0] == 8'd0);
            t_exc = (r[11:8] < 4'd2);
            t_eret = (r[15:12] < 4'd3);
            t_mtc0 = (r[19:16] < 4'd4);
            t_mfc0 = r[20];
            t_cause = r[25:21];
            r = $urandom;
            case (r % 6)
                0: t_addr = 5'd9;
                1: t_addr = 5'd11;
                2: t_addr = 5'd12;
                3: t_addr = 5'd13;
                4: t_addr = 5'd14;
                default: t_addr = r[12:8];
            endcase
            t_irq = (r[15:13] == 3'd0) ? r[20:16] : 5'd0;
            t_pc = $urandom & 32'hFFFFFFFC;
            t_wdata = $urandom;
            if (t_addr == 5'd11) t_wdata = m_cnt[0] + 32'($urandom_range(1, 12));
            if (t_addr == 5'd9 && r[21]) t_wdata = 32'hFFFFFFF8;
            tick();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
